// File: rtl/see_cone_inject_seq.sv
`default_nettype none
// ============================================================================
// Module  : see_cone_inject_seq
// Brief   : Exhaustive SEE flip-injection sequencer for a golden/faulty cone pair.
// Revision: 1.0
// ============================================================================
module see_cone_inject_seq #(
    parameter int N_IN    = 8,
    parameter int N_SITES = 6,
    parameter int SETTLE  = 2,
    parameter int CNT_W   = 16,
    localparam int c_SITE_W = (N_SITES > 1) ? $clog2(N_SITES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    output logic [N_IN-1:0]     vec,
    output logic [N_SITES-1:0]  flip_en,
    input  logic                golden_out,
    input  logic                faulty_out,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                site_valid,
    output logic [c_SITE_W-1:0] site_idx,
    output logic [CNT_W-1:0]    site_err,
    output logic [CNT_W-1:0]    err_total
);

    localparam int c_SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SETTLE    = 3'd1,
        S_COMPARE   = 3'd2,
        S_SITE_DONE = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_IN-1:0]     r_vec;
    logic [c_SITE_W-1:0] r_site;
    logic [CNT_W-1:0]    r_site_cnt;
    logic [CNT_W-1:0]    r_err_total;
    logic [c_SET_W-1:0]  r_settle_cnt;
    logic                r_aborted;

    logic w_active;
    logic w_abort_take;
    logic w_vec_last;
    logic w_site_last;
    logic w_settle_last;
    logic w_mismatch;

    assign w_active      = (r_state == S_SETTLE) || (r_state == S_COMPARE) ||
                           (r_state == S_SITE_DONE);
    assign w_abort_take  = abort && w_active;
    assign w_vec_last    = (r_vec == {N_IN{1'b1}});
    assign w_site_last   = (r_site == c_SITE_W'(N_SITES - 1));
    assign w_settle_last = (r_settle_cnt == c_SET_W'(SETTLE - 1));
    assign w_mismatch    = golden_out ^ faulty_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_abort_take) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:      if (start) w_state_nxt = S_SETTLE;
                S_SETTLE:    if (w_settle_last) w_state_nxt = S_COMPARE;
                S_COMPARE:   w_state_nxt = w_vec_last ? S_SITE_DONE : S_SETTLE;
                S_SITE_DONE: w_state_nxt = w_site_last ? S_DONE : S_SETTLE;
                S_DONE:      w_state_nxt = S_IDLE;
                default:     w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Abort suppresses every datapath update of the cycle it is taken in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec        <= '0;
            r_site       <= '0;
            r_site_cnt   <= '0;
            r_err_total  <= '0;
            r_settle_cnt <= '0;
            r_aborted    <= 1'b0;
        end else begin
            r_aborted <= w_abort_take;
            if (!w_abort_take) begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_vec        <= '0;
                            r_site       <= '0;
                            r_site_cnt   <= '0;
                            r_err_total  <= '0;
                            r_settle_cnt <= '0;
                        end
                    end
                    S_SETTLE: begin
                        r_settle_cnt <= w_settle_last ? '0 : r_settle_cnt + 1'b1;
                    end
                    S_COMPARE: begin
                        if (w_mismatch) begin
                            if (r_site_cnt != {CNT_W{1'b1}}) r_site_cnt <= r_site_cnt + 1'b1;
                            if (r_err_total != {CNT_W{1'b1}}) r_err_total <= r_err_total + 1'b1;
                        end
                        if (!w_vec_last) r_vec <= r_vec + 1'b1;
                    end
                    S_SITE_DONE: begin
                        if (!w_site_last) begin
                            r_site     <= r_site + 1'b1;
                            r_vec      <= '0;
                            r_site_cnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign vec        = r_vec;
    assign flip_en    = ((r_state == S_SETTLE) || (r_state == S_COMPARE)) ?
                        (N_SITES'(1) << r_site) : '0;
    assign busy       = w_active;
    assign done       = (r_state == S_DONE);
    assign aborted    = r_aborted;
    assign site_valid = (r_state == S_SITE_DONE) && !abort;
    assign site_idx   = r_site;
    assign site_err   = r_site_cnt;
    assign err_total  = r_err_total;

endmodule
`default_nettype wire

// File: tb/tb_see_cone_inject_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_see_cone_inject_seq
// Brief   : Scoreboard bench for see_cone_inject_seq (default and CNT_W=8 builds).
// Revision: 1.0
// ============================================================================
module tb_see_cone_inject_seq;

    typedef struct {
        int idx;
        int err;
    } site_exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic       start8;
    int         mode;

    logic [7:0]  vec,  vec8;
    logic [5:0]  flip_en, flip_en8;
    logic        golden_out, faulty_out, golden8, faulty8;
    logic        busy, done, aborted, site_valid;
    logic        busy8, done8, aborted8, site_valid8;
    logic [2:0]  site_idx, site_idx8;
    logic [15:0] site_err, err_total;
    logic [7:0]  site_err8, err_total8;

    int n_chk  = 0;
    int n_fail = 0;

    site_exp_t q[$];
    site_exp_t q8[$];
    site_exp_t e_m, e_8;
    logic [5:0] last_flip  = '0;
    logic [5:0] last_flip8 = '0;

    always #5 clk = ~clk;

    // Cone model: golden is vector parity; mode selects how the faulty copy deviates.
    assign golden_out = ^vec;
    always_comb begin
        faulty_out = golden_out;
        case (mode)
            1:       faulty_out = ~golden_out;
            2:       faulty_out = golden_out ^ (flip_en[2] & vec[0]);
            default: faulty_out = golden_out;
        endcase
    end
    assign golden8 = ^vec8;
    assign faulty8 = ~golden8;

    see_cone_inject_seq u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vec(vec), .flip_en(flip_en),
        .golden_out(golden_out), .faulty_out(faulty_out),
        .busy(busy), .done(done), .aborted(aborted),
        .site_valid(site_valid), .site_idx(site_idx),
        .site_err(site_err), .err_total(err_total)
    );

    see_cone_inject_seq #(.CNT_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .abort(1'b0),
        .vec(vec8), .flip_en(flip_en8),
        .golden_out(golden8), .faulty_out(faulty8),
        .busy(busy8), .done(done8), .aborted(aborted8),
        .site_valid(site_valid8), .site_idx(site_idx8),
        .site_err(site_err8), .err_total(err_total8)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (flip_en != '0) last_flip = flip_en;
            if (site_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_site_valid", 1, 0);
                end else begin
                    e_m = q.pop_front();
                    chk("site_idx", site_idx, e_m.idx);
                    chk("site_err", site_err, e_m.err);
                    chk("flip_onehot", last_flip, 64'd1 << e_m.idx);
                    chk("flip_zero_site_done", flip_en, 0);
                end
                last_flip = '0;
            end
            if (flip_en8 != '0) last_flip8 = flip_en8;
            if (site_valid8) begin
                if (q8.size() == 0) begin
                    chk("unexpected_site_valid8", 1, 0);
                end else begin
                    e_8 = q8.pop_front();
                    chk("site_idx8", site_idx8, e_8.idx);
                    chk("site_err8_sat", site_err8, e_8.err);
                    chk("flip_onehot8", last_flip8, 64'd1 << e_8.idx);
                end
                last_flip8 = '0;
            end
        end
    end

    task automatic run_campaign(input int m, input int exp_site[6], input int exp_total,
                                input bit chk_time, input bit with8, input bit with_abort);
        int  n;
        bit  seen;
        @(negedge clk);
        mode = m;
        for (int s = 0; s < 6; s++) q.push_back(site_exp_t'{s, exp_site[s]});
        if (with8) for (int s = 0; s < 6; s++) q8.push_back(site_exp_t'{s, 255});
        start  = 1'b1;
        start8 = with8;
        abort  = with_abort;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        start8 = 1'b0;
        abort  = 1'b0;
        chk("start_accepted_no_abort", {busy, aborted}, 2'b10);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 6000) begin
            if (done) seen = 1'b1;
            else begin
                @(posedge clk);
                n++;
                @(negedge clk);
            end
        end
        chk("done_seen", seen, 1);
        if (chk_time) chk("done_fall_cycle", n + 1, 4615);
        chk("err_total", err_total, exp_total);
        chk("busy_low_in_done", busy, 0);
        chk("scoreboard_drained", q.size(), 0);
        if (with8) begin
            chk("done8", done8, 1);
            chk("err_total8_sat", err_total8, 255);
            chk("scoreboard8_drained", q8.size(), 0);
        end
        @(negedge clk);
        chk("done_single_pulse", done, 0);
        chk("err_total_held", err_total, exp_total);
    endtask

    task automatic abort_test();
        int n;
        @(negedge clk);
        mode = 1;
        for (int s = 0; s < 6; s++) q.push_back(site_exp_t'{s, 256});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(vec == 8'd10 && flip_en == 6'b001000) && n < 10000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_abort_point", n < 10000, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("aborted_pulse", aborted, 1);
        chk("abort_busy", busy, 0);
        chk("abort_flip_en", flip_en, 0);
        chk("abort_no_done", done, 0);
        chk("abort_no_site_valid", site_valid, 0);
        chk("abort_err_total", err_total, 3 * 256 + 10);
        chk("sites_before_abort", q.size(), 3);
        q.delete();
        @(negedge clk);
        chk("aborted_single_pulse", aborted, 0);
        chk("abort_err_total_held", err_total, 3 * 256 + 10);
    endtask

    task automatic reset_test();
        int n;
        @(negedge clk);
        mode = 0;
        for (int s = 0; s < 6; s++) q.push_back(site_exp_t'{s, 0});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (vec != 8'd5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_vec5", vec, 5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored_vec", vec, 5);
        chk("start_ignored_busy", busy, 1);
        n = 0;
        while (vec != 8'd7 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("reach_vec7_settle", flip_en, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_vec", vec, 0);
        chk("async_rst_flip_busy", {flip_en, busy, done, aborted, site_valid}, 0);
        chk("async_rst_counters", {site_idx, site_err, err_total}, 0);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        start8 = 1'b0;
        mode   = 0;
        #12;
        chk("reset_vec_flip", {vec, flip_en}, 0);
        chk("reset_status", {busy, done, aborted, site_valid}, 0);
        chk("reset_counters", {site_idx, site_err, err_total}, 0);
        @(negedge clk);
        rst = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle_ignored", {aborted, busy}, 0);

        run_campaign(0, '{0, 0, 0, 0, 0, 0}, 0, 1'b1, 1'b0, 1'b0);
        run_campaign(1, '{256, 256, 256, 256, 256, 256}, 1536, 1'b1, 1'b1, 1'b0);
        run_campaign(2, '{0, 0, 128, 0, 0, 0}, 128, 1'b1, 1'b0, 1'b1);
        abort_test();
        run_campaign(1, '{256, 256, 256, 256, 256, 256}, 1536, 1'b0, 1'b0, 1'b0);
        reset_test();
        run_campaign(0, '{0, 0, 0, 0, 0, 0}, 0, 1'b1, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
